// File: rtl/fpu_pkg.sv
// Shared FPU definitions: significand/product widths, Booth iteration count,
// exception codes and the Booth multiplier state encoding.
package fpu_pkg;

  localparam int MANT_W      = 24;
  localparam int PROD_W      = 48;
  localparam int BOOTH_STEPS = 13;

  localparam logic [2:0] EXC_NONE = 3'b000;

  typedef enum logic [1:0] {
    BOOTH_IDLE     = 2'd0,
    BOOTH_RUN      = 2'd1,
    BOOTH_DONE     = 2'd2,
    BOOTH_WAIT_LOW = 2'd3
  } booth_state_t;

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier group {q[i+1], q[i], q[i-1]}
// to a digit in {-2,-1,0,+1,+2} expressed as sign / x1 / x2 selects.
module booth_r4_digit (
  input  logic [2:0] grp,
  output logic       neg,
  output logic       one,
  output logic       two
);

  // 111 is encoded as +0 rather than -0 so no spurious negation happens.
  always_comb begin
    one = grp[1] ^ grp[0];
    two = (grp == 3'b011) || (grp == 3'b100);
    neg = grp[2] && !(grp[1] && grp[0]);
  end

endmodule

// File: rtl/booth_mul24.sv
// Sequential radix-4 Booth multiplier for 24-bit unsigned significands.
// Handshake: Valid is a level held by the caller until it sees Ack; Ack is a
// one-cycle pulse with Dataout valid in that cycle; the block then waits in
// WAIT_LOW until Valid drops so a lagging Valid cannot retrigger it.
module booth_mul24
  import fpu_pkg::*;
#(
  parameter int MANT_W = fpu_pkg::MANT_W,
  parameter int STEPS  = fpu_pkg::BOOTH_STEPS
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [MANT_W-1:0]     Datain1,
  input  logic [MANT_W-1:0]     Datain2,
  input  logic                  Valid,
  output logic [2*MANT_W-1:0]   Dataout,
  output logic [2:0]            Exc,
  output logic                  Ack,
  output logic                  Busy,
  output booth_state_t          state_dbg
);

  localparam int ACC_W = MANT_W + 4;   // signed accumulator, room for +-2A
  localparam int MQ_W  = MANT_W + 3;   // {2'b00, multiplier, q-1}
  localparam int CNT_W = 4;
  localparam int FULL_W = ACC_W + MQ_W - 1;

  booth_state_t            state, state_n;
  logic [MANT_W-1:0]       mcand, mcand_n;
  logic [MQ_W-1:0]         mreg, mreg_n;
  logic [ACC_W-1:0]        acc, acc_n;
  logic [CNT_W-1:0]        step, step_n;
  logic [2*MANT_W-1:0]     dout_n;
  logic                    ack_n, busy_n;

  logic                    d_neg, d_one, d_two;
  logic [ACC_W-1:0]        addend_mag, addend, sum;
  logic [FULL_W-1:0]       prod_full;
  logic                    finishing;

  booth_r4_digit u_digit (
    .grp (mreg[2:0]),
    .neg (d_neg),
    .one (d_one),
    .two (d_two)
  );

  assign Exc       = EXC_NONE;
  assign state_dbg = state;

  // Next-state, Booth add/shift datapath and registered-output values.
  always_comb begin
    state_n   = state;
    mcand_n   = mcand;
    mreg_n    = mreg;
    acc_n     = acc;
    step_n    = step;
    dout_n    = Dataout;
    ack_n     = 1'b0;
    finishing = 1'b0;

    if (d_one)      addend_mag = {4'b0000, mcand};
    else if (d_two) addend_mag = {3'b000, mcand, 1'b0};
    else            addend_mag = '0;
    addend    = d_neg ? (~addend_mag + 1'b1) : addend_mag;
    sum       = acc + addend;
    prod_full = '0;

    case (state)
      BOOTH_IDLE: begin
        if (Valid) begin
          mcand_n = Datain1;
          mreg_n  = {2'b00, Datain2, 1'b0};
          acc_n   = '0;
          step_n  = '0;
          if ((Datain1 == '0) || (Datain2 == '0)) begin
            dout_n  = '0;
            ack_n   = 1'b1;
            state_n = BOOTH_DONE;
          end else begin
            state_n = BOOTH_RUN;
          end
        end
      end
      BOOTH_RUN: begin
        // Add d*A, then arithmetic shift of {acc, mreg} right by two.
        acc_n     = {sum[ACC_W-1], sum[ACC_W-1], sum[ACC_W-1:2]};
        mreg_n    = {sum[1:0], mreg[MQ_W-1:2]};
        step_n    = step + 1'b1;
        prod_full = {acc_n, mreg_n[MQ_W-1:1]};
        if (step == CNT_W'(STEPS - 1)) begin
          finishing = 1'b1;
          dout_n    = prod_full[2*MANT_W-1:0];
          ack_n     = 1'b1;
          state_n   = BOOTH_DONE;
        end
      end
      BOOTH_DONE: begin
        state_n = BOOTH_WAIT_LOW;
      end
      BOOTH_WAIT_LOW: begin
        if (!Valid) state_n = BOOTH_IDLE;
      end
      default: state_n = BOOTH_IDLE;
    endcase

    busy_n = (state_n != BOOTH_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= BOOTH_IDLE;
      mcand   <= '0;
      mreg    <= '0;
      acc     <= '0;
      step    <= '0;
      Dataout <= '0;
      Ack     <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      state   <= state_n;
      mcand   <= mcand_n;
      mreg    <= mreg_n;
      acc     <= acc_n;
      step    <= step_n;
      Dataout <= dout_n;
      Ack     <= ack_n;
      Busy    <= busy_n;
    end
  end

  // Unsigned 24x24 products never reach bit 48 of the full register pair.
  a_prod_hi_zero : assert property (@(posedge CLK) disable iff (!RSTn)
    finishing |-> (prod_full[FULL_W-1:2*MANT_W] == '0));

endmodule

// File: tb/tb_booth_mul24.sv
// Self-checking bench for booth_mul24: directed vectors plus a random run,
// expected products pushed at issue time and checked by an Ack monitor.
module tb_booth_mul24;
  import fpu_pkg::*;

  logic               CLK;
  logic               RSTn;
  logic [23:0]        Datain1, Datain2;
  logic               Valid;
  logic [47:0]        Dataout;
  logic [2:0]         Exc;
  logic               Ack;
  logic               Busy;
  booth_state_t       state_dbg;

  booth_mul24 dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Datain1   (Datain1),
    .Datain2   (Datain2),
    .Valid     (Valid),
    .Dataout   (Dataout),
    .Exc       (Exc),
    .Ack       (Ack),
    .Busy      (Busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cycle = 0;
  always @(posedge CLK) cycle <= cycle + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  int          lat_q[$];
  int          runs_q[$];
  int          cap_cycle = 0;
  int          run_cnt   = 0;
  int          tests     = 0;
  int          fails     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    check("busy_vs_state", 64'(Busy), 64'(state_dbg != BOOTH_IDLE));
    if (state_dbg == BOOTH_RUN) run_cnt++;
    else if (state_dbg == BOOTH_IDLE) run_cnt = 0;
    if (Ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got Ack=1 with Dataout %h expected no Ack", Dataout);
      end else begin
        check("dataout", 64'(Dataout), 64'(exp_q.pop_front()));
        check("exc", 64'(Exc), 64'(EXC_NONE));
        check("latency", 64'(cycle - cap_cycle + 1), 64'(lat_q.pop_front()));
        check("run_cycles", 64'(run_cnt), 64'(runs_q.pop_front()));
      end
      run_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (state_dbg != BOOTH_IDLE && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (state_dbg != BOOTH_IDLE) check("wait_idle_timeout", 64'(state_dbg), 64'(BOOTH_IDLE));
  endtask

  task automatic do_req(input logic [23:0] a, input logic [23:0] b,
                        input logic [47:0] prod, input int hold);
    int n = 0;
    bit zero_op;
    wait_idle();
    zero_op = (a == 24'd0) || (b == 24'd0);
    exp_q.push_back(prod);
    lat_q.push_back(zero_op ? 1 : 14);
    runs_q.push_back(zero_op ? 0 : 13);
    Datain1   = a;
    Datain2   = b;
    Valid     = 1'b1;
    cap_cycle = cycle + 1;
    @(negedge CLK);
    // operands must be ignored once captured
    Datain1 = 24'($urandom);
    Datain2 = 24'($urandom);
    while (!Ack && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!Ack) begin
      check("ack_timeout", 64'(Ack), 64'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      void'(runs_q.pop_front());
    end
    repeat (hold) @(negedge CLK);
    Valid = 1'b0;
  endtask

  task automatic reset_mid_run();
    int n = 0;
    wait_idle();
    Datain1 = 24'h123456;
    Datain2 = 24'h654321;
    Valid   = 1'b1;
    @(negedge CLK);
    while (n < 6) begin
      if (state_dbg == BOOTH_RUN) n++;
      if (n < 6) @(negedge CLK);
      if (cycle > cap_cycle + 100000) break;
    end
    RSTn  = 1'b0;
    Valid = 1'b0;
    @(negedge CLK);
    check("rst_ack", 64'(Ack), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_dataout", 64'(Dataout), 64'd0);
    check("rst_exc", 64'(Exc), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(BOOTH_IDLE));
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [23:0] a, b;
    RSTn    = 1'b0;
    Valid   = 1'b0;
    Datain1 = '0;
    Datain2 = '0;
    repeat (3) @(negedge CLK);
    check("reset_dataout", 64'(Dataout), 64'd0);
    check("reset_ack", 64'(Ack), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_exc", 64'(Exc), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);

    do_req(24'h800000, 24'h800000, 48'h400000000000, 0);
    do_req(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 0);
    do_req(24'h000000, 24'hC00000, 48'h000000000000, 0);
    do_req(24'hC00000, 24'h000000, 48'h000000000000, 1);
    do_req(24'h800000, 24'hC00000, 48'h600000000000, 3);
    do_req(24'h000001, 24'h000001, 48'h000000000001, 0);
    do_req(24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 0);
    do_req(24'h000002, 24'h800000, 48'h000001000000, 2);
    do_req(24'hAAAAAA, 24'h000003, 48'h000001FFFFFE, 0);

    reset_mid_run();
    do_req(24'hA00000, 24'h900000, 48'h5A0000000000, 0);

    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if ($urandom_range(0, 19) == 0) a = 24'd0;
      if ($urandom_range(0, 19) == 0) b = 24'd0;
      do_req(a, b, 48'(a) * 48'(b), $urandom_range(0, 2));
    end

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_mul24.md
# booth_mul24

Sequential radix-4 Booth multiplier for 24-bit unsigned significands (hidden bit included). It produces the 48-bit product consumed by the FPU multiplication controller, which normalises, rounds and packs the result. It connects to the controller through a level-valid / pulse-ack handshake. It runs one multiplication at a time and takes 13 iteration cycles, with a one-cycle fast path when either operand is zero.

## Interface

Parameters:
- MANT_W, 24, significand width; fixed at 24 for this revision.
- STEPS, 13, radix-4 iterations, equal to ceil((MANT_W+2)/2).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RSTn  in  1  synchronous, active-low reset.
- Datain1  in  24  multiplicand (unsigned significand).
- Datain2  in  24  multiplier (unsigned significand).
- Valid  in  1  request; level, held by the caller until Ack is seen.
- Dataout  out  48  product Datain1*Datain2; reset value 0.
- Exc  out  3  exception code; always 3'b000 in this block (reserved); reset value 0.
- Ack  out  1  one-cycle pulse, Dataout valid in the same cycle; reset value 0.
- Busy  out  1  high in RUN, DONE and WAIT_LOW; reset value 0.

## Operation

- States:
  - IDLE: wait for a request.
  - RUN: perform the Booth iterations.
  - DONE: present the result.
  - WAIT_LOW: wait for the caller to drop Valid.
- IDLE with Valid=1 captures both operands.
  - If either operand is 0: load Dataout=0 and go to DONE.
  - Otherwise: go to RUN with step counter = 0.
- RUN datapath:
  - Multiplier register is {2'b00, Datain2, 1'b0}, 27 bits including the appended q-1 bit.
  - Accumulator is 28-bit signed, cleared at capture.
  - Each cycle, the low 3 bits of the multiplier register select a digit d in {-2,-1,0,+1,+2}. Add d*A to the accumulator, where A is zero-extended to 28 bits and -A is formed by two's complement.
  - Then shift {accumulator, multiplier register} right by 2 arithmetically.
  - After STEPS cycles, the product is the low 48 bits of {accumulator, multiplier[26:1]}. Bits above 47 must be zero; verification asserts this.
  - Go to DONE.
- DONE:
  - Ack=1 and Dataout carries the product; exactly one cycle.
  - Next state is WAIT_LOW.
- WAIT_LOW:
  - Stay while Valid=1. The caller's registered valid lags Ack by one cycle, and this state prevents a retrigger.
  - Go to IDLE when Valid=0.
- Dataout holds its value from DONE until the next DONE or reset.
- Operand changes on Datain1/Datain2 after capture are ignored.

## Timing

- Capture edge is E0 (IDLE, Valid=1).
- Nonzero operands: RUN occupies E1..E13 and Ack is high in the cycle after E13. Latency from capture edge to Ack is 14 cycles.
- Zero operand: Ack is high in the cycle after E0, a latency of 1 cycle.
- Minimum request spacing: capture, then Ack, then one cycle in WAIT_LOW with Valid=0, then IDLE. The next capture happens on the following edge.
- Valid already high when IDLE is entered: it is captured on that edge as a new request. This is legal only after Valid has been seen low in WAIT_LOW.
- Reset at any time, including mid-RUN:
  - On the next edge the state goes to IDLE and Ack, Busy, Dataout and Exc go to 0.
  - The partial result is discarded and no Ack is emitted.
- Valid dropping mid-RUN is not abort. The operation completes and Ack still pulses.

## Structure

- Shared package fpu_pkg holds:
  - enum booth_state_t {BOOTH_IDLE, BOOTH_RUN, BOOTH_DONE, BOOTH_WAIT_LOW};
  - localparams MANT_W=24, PROD_W=48, BOOTH_STEPS=13, EXC_NONE=3'b000.
- Sub-module booth_r4_digit (combinational):
  - Input: 3-bit group.
  - Outputs: neg, one, two selects.
  - Instantiated once in the datapath.
- Top: one sequential always block for state and registers, and one combinational next-state/datapath block with all defaults assigned first.

## Test plan

- 24'h800000 × 24'h800000 (1.0×1.0) -> Ack 14 cycles after capture, Dataout=48'h400000000000, Exc=0.
- 24'hFFFFFF × 24'hFFFFFF -> Dataout=48'hFFFFFE000001; no bits set above 47.
- 24'h000000 × 24'hC00000 -> Ack 1 cycle after capture, Dataout=0, no RUN cycles.
- 24'h800000 × 24'hC00000 with Valid held high 3 cycles past Ack -> single Ack pulse, Dataout=48'h600000000000, no second capture until Valid falls.
- RSTn=0 asserted at RUN step 6 -> all outputs 0 next edge, no Ack. A following request 24'hA00000 × 24'h900000 then gives 48'h5A0000000000.
- 1000 random back-to-back requests against a reference model -> every product matches, exactly one Ack per request, and Busy is low only in IDLE.
